// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI target engine: FSM encodings, frame width,
// default idle fill byte and a bit-order helper.
package spi_pkg;

    localparam int SPI_FRAME_BITS = 8;
    localparam int SPI_CNT_W      = 3;
    localparam logic [SPI_FRAME_BITS-1:0] SPI_IDLE_FILL = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_DONE   = 2'd3
    } spi_state_e;

    // Bit at frame position idx (0 = first on the wire) for the selected bit order.
    function automatic logic frame_bit(input logic [SPI_FRAME_BITS-1:0] data,
                                       input logic [SPI_CNT_W-1:0]      idx,
                                       input logic                      lsb_first);
        logic bit_s;
        if (lsb_first) begin
            bit_s = data[idx];
        end else begin
            bit_s = data[3'd7 - idx];
        end
        return bit_s;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchronizer followed by a delay flop; reports the synced level and any
// change of that level (toggle) so the caller can qualify rising/falling edges.
module spi_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_in,
    input  logic rstn_in,
    input  logic async_in,
    output logic sync_o,
    output logic toggle_o
);

    logic [STAGES-1:0] sync_q;
    logic              dly_q;

    // Synchronizer chain plus one delay stage for edge detection.
    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            sync_q <= {STAGES{RESET_VAL}};
            dly_q  <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_in};
            dly_q  <= sync_q[STAGES-1];
        end
    end

    assign sync_o   = sync_q[STAGES-1];
    assign toggle_o = sync_q[STAGES-1] ^ dly_q;

endmodule

// File: rtl/spi_slave_core.sv
// SPI target engine: oversampled SCK/SS/MOSI, 8-bit frames, CPOL/CPHA modes 0-3,
// LSB-first option. Optional rx overrun tracking under `SPI_SLAVE_OVERRUN_EN.
module spi_slave_core
    import spi_pkg::*;
#(
    parameter int                        SYNC_STAGES = 2,
    parameter logic [SPI_FRAME_BITS-1:0] IDLE_FILL   = SPI_IDLE_FILL
) (
    input  logic       clk_in,
    input  logic       rstn_in,
    input  logic       enable_in,
    input  logic       cpol_in,
    input  logic       cpha_in,
    input  logic       lsbfe_in,
    input  logic       sck_in,
    input  logic       ss_in,
    input  logic       serial_in,
    output logic       serial_out,
    output logic       miso_oe_out,
    input  logic [7:0] tx_data_in,
    input  logic       tx_load_in,
    output logic       tx_empty_out,
    output logic [7:0] rx_data_out,
    output logic       rx_valid_out,
`ifdef SPI_SLAVE_OVERRUN_EN
    input  logic       rx_ack_in,
    output logic       overrun_out,
`endif
    output logic       busy_out
);

    spi_state_e           state_q, state_d;
    logic [SPI_CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]           rx_sh_q, rx_sh_d;
    logic [7:0]           tx_sh_q, tx_sh_d;
    logic [7:0]           tx_buf_q, tx_buf_d;
    logic [7:0]           rx_data_q, rx_data_d;
    logic                 tx_empty_q, tx_empty_d;
    logic                 serial_q, serial_d;
    logic                 oe_q, oe_d;
    logic                 busy_q, busy_d;
    logic                 rx_valid_q, rx_valid_d;

    logic                   sck_s, sck_tgl_s, ss_s, ss_tgl_s, mosi_s;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   lead_s, trail_s, sample_s, shift_s, ss_fall_s;
    logic [7:0]             load_byte_s, rx_ins_s;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
        .clk_in   (clk_in),
        .rstn_in  (rstn_in),
        .async_in (sck_in),
        .sync_o   (sck_s),
        .toggle_o (sck_tgl_s)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ss_sync (
        .clk_in   (clk_in),
        .rstn_in  (rstn_in),
        .async_in (ss_in),
        .sync_o   (ss_s),
        .toggle_o (ss_tgl_s)
    );

    // MOSI needs no edge detect; its last stage lines up with the synced SCK edge.
    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            mosi_sync_q <= {SYNC_STAGES{1'b0}};
        end else begin
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], serial_in};
        end
    end

    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign lead_s    = sck_tgl_s & (sck_s ^ cpol_in);
    assign trail_s   = sck_tgl_s & ~(sck_s ^ cpol_in);
    assign sample_s  = cpha_in ? trail_s : lead_s;
    assign shift_s   = cpha_in ? lead_s : trail_s;
    assign ss_fall_s = ss_tgl_s & ~ss_s;

    assign load_byte_s = tx_empty_q ? IDLE_FILL : tx_buf_q;
    assign rx_ins_s    = lsbfe_in ? {mosi_s, rx_sh_q[7:1]} : {rx_sh_q[6:0], mosi_s};

    // Next-state logic for the frame FSM, datapath and tx buffer.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rx_sh_d    = rx_sh_q;
        tx_sh_d    = tx_sh_q;
        tx_buf_d   = tx_buf_q;
        tx_empty_d = tx_empty_q;
        serial_d   = serial_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;

        if (!enable_in) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ss_fall_s) begin
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    tx_sh_d    = load_byte_s;
                    tx_empty_d = 1'b1;
                    cnt_d      = {SPI_CNT_W{1'b0}};
                    serial_d   = frame_bit(load_byte_s, {SPI_CNT_W{1'b0}}, lsbfe_in);
                    if (ss_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (ss_s) begin
                        state_d = ST_IDLE;
                    end else if (sample_s) begin
                        rx_sh_d = rx_ins_s;
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            rx_data_d  = rx_ins_s;
                            rx_valid_d = 1'b1;
                            state_d    = ST_DONE;
                        end else begin
                            state_d = ST_ACTIVE;
                        end
                    end else if (shift_s && (cpha_in || (cnt_q != 3'd0))) begin
                        // Position == samples taken so far; CPHA=0 ignores the edge before any sample.
                        serial_d = frame_bit(tx_sh_q, cnt_q, lsbfe_in);
                    end else begin
                        state_d = ST_ACTIVE;
                    end
                end
                ST_DONE: begin
                    if (ss_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // A same-cycle load stays pending even while LOAD consumes the old content.
        if (tx_load_in) begin
            tx_buf_d   = tx_data_in;
            tx_empty_d = 1'b0;
        end else begin
            tx_buf_d = tx_buf_q;
        end

        if (state_d == ST_IDLE) begin
            serial_d = 1'b0;
            oe_d     = 1'b0;
            busy_d   = 1'b0;
        end else begin
            oe_d   = 1'b1;
            busy_d = 1'b1;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            state_q    <= ST_IDLE;
            cnt_q      <= {SPI_CNT_W{1'b0}};
            rx_sh_q    <= 8'h00;
            tx_sh_q    <= 8'h00;
            tx_buf_q   <= 8'h00;
            tx_empty_q <= 1'b1;
            serial_q   <= 1'b0;
            oe_q       <= 1'b0;
            busy_q     <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rx_sh_q    <= rx_sh_d;
            tx_sh_q    <= tx_sh_d;
            tx_buf_q   <= tx_buf_d;
            tx_empty_q <= tx_empty_d;
            serial_q   <= serial_d;
            oe_q       <= oe_d;
            busy_q     <= busy_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

`ifdef SPI_SLAVE_OVERRUN_EN
    logic pending_q;
    logic overrun_q;

    // Unacknowledged byte tracking; overrun is sticky until acknowledged.
    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else if (rx_valid_d) begin
            pending_q <= 1'b1;
            overrun_q <= (overrun_q | pending_q) & ~rx_ack_in;
        end else if (rx_ack_in) begin
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            pending_q <= pending_q;
            overrun_q <= overrun_q;
        end
    end

    assign overrun_out = overrun_q;
`endif

    assign serial_out   = serial_q;
    assign miso_oe_out  = oe_q;
    assign busy_out     = busy_q;
    assign tx_empty_out = tx_empty_q;
    assign rx_data_out  = rx_data_q;
    assign rx_valid_out = rx_valid_q;

endmodule
